demux_1x4_deser: RTL and testbench

- Serial-to-parallel counterpart of the equalizer's 4:1 output select path.
- Accepts one sample per handshake on a single input stream and steers consecutive samples into four lanes, in the order lane 1 to lane 4.
- Presents each completed 4-sample word on four parallel outputs with a valid/ready handshake.
- Sits at the front of the parallel FFE datapath. Lane order matches select codes 00..11 (lane1..lane4), so a 4:1 select reproduces the original stream.

---
 rtl/demux_1x4_deser_if.sv | 36 +++
 rtl/demux_1x4_deser.sv | 87 ++++++++
 tb/tb_demux_1x4_deser.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/demux_1x4_deser_if.sv
// rtl/demux_1x4_deser_if.sv - stream and lane bundle for the 1:4 deserialiser
//
// Signals:
//   align                 clear the lane counter and drop any partial word
//   in_data/in_valid      serial sample input
//   in_ready              sample can be taken this cycle
//   out1..out4            parallel word, lane 1 holds the first sample
//   out_valid/out_ready   word handshake
//   sel                   next lane to be written
// Modports: master drives the stream and consumes the word; slave is the deserialiser.

interface demux_1x4_deser_if #(
    parameter int data_width = 12
);
    logic                  align;
    logic [data_width-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] out1;
    logic [data_width-1:0] out2;
    logic [data_width-1:0] out3;
    logic [data_width-1:0] out4;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            sel;

    modport master (
        output align, in_data, in_valid, out_ready,
        input  in_ready, out1, out2, out3, out4, out_valid, sel
    );

    modport slave (
        input  align, in_data, in_valid, out_ready,
        output in_ready, out1, out2, out3, out4, out_valid, sel
    );
endinterface

// File: rtl/demux_1x4_deser.sv
// rtl/demux_1x4_deser.sv - serial to 4-lane parallel deserialiser with valid/ready
//
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous active-low reset
//   bus   demux_1x4_deser_if.slave (stream in, 4-lane word out, align, sel)
// Consecutive accepted samples fill lanes 1..4; the fourth sample is written
// straight into out4 together with the three buffered lanes, so a full word
// appears the cycle after its last sample with no bubble.

module demux_1x4_deser #(
    parameter int data_width = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    demux_1x4_deser_if.slave      bus
);
    logic [data_width-1:0] lane0;
    logic [data_width-1:0] lane1;
    logic [data_width-1:0] lane2;
    logic [1:0]            sel;
    logic                  out_valid;
    logic [data_width-1:0] out1;
    logic [data_width-1:0] out2;
    logic [data_width-1:0] out3;
    logic [data_width-1:0] out4;
    logic                  acc;
    logic                  complete;
    logic                  drain;

    // Only the last sample of a word has to wait for the output register to free up.
    assign bus.in_ready = !((sel == 2'd3) && out_valid && !bus.out_ready);
    assign acc          = bus.in_valid && bus.in_ready;
    // align restarts the word, so a sample arriving with it never completes one.
    assign complete     = acc && (sel == 2'd3) && !bus.align;
    assign drain        = out_valid && bus.out_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sel   <= 2'd0;
            lane0 <= '0;
            lane1 <= '0;
            lane2 <= '0;
        end else if (acc) begin
            if (bus.align) begin
                lane0 <= bus.in_data;
                sel   <= 2'd1;
            end else begin
                case (sel)
                    2'd0:    lane0 <= bus.in_data;
                    2'd1:    lane1 <= bus.in_data;
                    2'd2:    lane2 <= bus.in_data;
                    default: ;
                endcase
                sel <= sel + 2'd1;
            end
        end else if (bus.align) begin
            sel <= 2'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            // Also covers drain-and-complete in one cycle: reload, valid stays high.
            out1      <= lane0;
            out2      <= lane1;
            out3      <= lane2;
            out4      <= bus.in_data;
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.sel       = sel;
    assign bus.out_valid = out_valid;
    assign bus.out1      = out1;
    assign bus.out2      = out2;
    assign bus.out3      = out3;
    assign bus.out4      = out4;
endmodule

// File: tb/tb_demux_1x4_deser.sv
// tb/tb_demux_1x4_deser.sv - self-checking bench for demux_1x4_deser

module tb_demux_1x4_deser;
    localparam int DW = 12;

    logic CLK;
    logic RST;
    int   tests;
    int   fails;

    demux_1x4_deser_if #(.data_width(DW)) bus ();

    demux_1x4_deser #(.data_width(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: the partial word is a queue of accepted samples; its length is sel.
    int          m_part[$];
    int          m_out[4];
    bit          m_ov;
    int          ov_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 0;
        m_ov = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".sel"},  64'(bus.sel), 64'(m_part.size()));
        check({tag, ".ov"},   64'(bus.out_valid), 64'(m_ov));
        check({tag, ".out1"}, 64'(bus.out1), 64'(m_out[0]));
        check({tag, ".out2"}, 64'(bus.out2), 64'(m_out[1]));
        check({tag, ".out3"}, 64'(bus.out3), 64'(m_out[2]));
        check({tag, ".out4"}, 64'(bus.out4), 64'(m_out[3]));
    endtask

    // One clock: drive inputs, check in_ready, clock, advance the model, check state.
    task automatic step(input string tag, input bit v, input int d, input bit r, input bit a);
        bit exp_rdy;
        bit acc;
        bit drain;
        bit comp;
        bus.in_valid  = v;
        bus.in_data   = DW'(d);
        bus.out_ready = r;
        bus.align     = a;
        exp_rdy = !(m_part.size() == 3 && m_ov && !r);
        #1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
        @(posedge CLK);
        acc   = v && exp_rdy;
        drain = m_ov && r;
        comp  = 1'b0;
        if (acc) begin
            if (a) begin
                m_part.delete();
                m_part.push_back(d);
            end else if (m_part.size() == 3) begin
                for (int i = 0; i < 3; i++) m_out[i] = m_part[i];
                m_out[3] = d;
                m_part.delete();
                comp = 1'b1;
            end else begin
                m_part.push_back(d);
            end
        end else if (a) begin
            m_part.delete();
        end
        if (comp)       m_ov = 1'b1;
        else if (drain) m_ov = 1'b0;
        #1;
        check_state(tag);
        if (bus.out_valid) ov_count++;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ov_count = 0;
        model_reset();
        RST = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.align = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        check_state("reset");
        #2 RST = 1'b1;

        // Basic word, out_valid high for one cycle.
        for (int i = 1; i <= 4; i++) step("t1", 1, i, 1, 0);
        check("t1.out1_const", 64'(bus.out1), 64'h001);
        check("t1.out4_const", 64'(bus.out4), 64'h004);
        check("t1.ov_const", 64'(bus.out_valid), 64'd1);
        step("t1.idle", 0, 12'h5a5, 1, 0);
        check("t1.ov_drop", 64'(bus.out_valid), 64'd0);

        // Continuous 12 samples: three single-cycle words.
        ov_count = 0;
        for (int i = 0; i < 12; i++) step("t2", 1, 'h010 + i, 1, 0);
        step("t2.idle", 0, 0, 1, 0);
        check("t2.words", 64'(ov_count), 64'd3);
        check("t2.last_out4", 64'(bus.out4), 64'h01b);

        // Back-pressure: 4th sample of next word waits for drain.
        for (int i = 0; i < 4; i++) step("t3a", 1, 'h100 + i, 0, 0);
        for (int i = 4; i < 8; i++) step("t3b", 1, 'h104 + (i - 4) - ((i == 7) ? 0 : 0), 0, 0);
        check("t3.stall_out1", 64'(bus.out1), 64'h100);
        check("t3.stall_sel", 64'(bus.sel), 64'd3);
        step("t3c", 1, 'h107, 1, 0);
        check("t3.reload_out1", 64'(bus.out1), 64'h104);
        check("t3.reload_ov", 64'(bus.out_valid), 64'd1);
        step("t3d", 0, 0, 1, 0);

        // Align discards partial word.
        step("t4", 1, 'haaa, 1, 0);
        step("t4", 1, 'hbbb, 1, 0);
        step("t4", 1, 'hccc, 1, 1);
        step("t4", 1, 'hddd, 1, 0);
        step("t4", 1, 'heee, 1, 0);
        step("t4", 1, 'hfff, 1, 0);
        check("t4.out1_const", 64'(bus.out1), 64'hccc);
        step("t4", 1, 'h123, 1, 0);
        step("t4", 1, 'h124, 1, 0);
        step("t4", 1, 'h125, 1, 0);
        step("t4.align_at3", 1, 'h126, 1, 1);
        check("t4.align_at3_sel", 64'(bus.sel), 64'd1);

        // Toggled in_valid with garbage data on idle cycles.
        step("t5.realign", 0, 0, 1, 1);
        for (int i = 5; i <= 8; i++) begin
            step("t5", 1, i, 1, 0);
            step("t5.gap", 0, 12'hf0f, 1, 0);
        end

        // Asynchronous reset mid-word.
        step("t6", 1, 'h031, 1, 0);
        step("t6", 1, 'h032, 1, 0);
        #2 RST = 1'b0;
        #1;
        model_reset();
        check_state("t6.async");
        #3 RST = 1'b1;

        // Asynchronous reset while a word is held.
        for (int i = 0; i < 4; i++) step("t6b", 1, 'h040 + i, 0, 0);
        check("t6b.ov_before", 64'(bus.out_valid), 64'd1);
        #2 RST = 1'b0;
        #1;
        model_reset();
        check_state("t6b.async");
        #3 RST = 1'b1;
        for (int i = 0; i < 4; i++) step("t6c", 1, 'h050 + i, 1, 0);
        check("t6c.out1_const", 64'(bus.out1), 64'h050);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            step("rand",
                 ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 4095)),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
